bsg_locking_arb_unlocker: RTL and testbench

//  Consumer side of a locking fixed-priority arbiter. Accepts the arbiter's one-hot

---
 rtl/bsg_locking_arb_unlocker.sv | 132 +++++++++++++
 tb/tb_bsg_locking_arb_unlocker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_locking_arb_unlocker.sv
// Consumer side of a locking fixed-priority arbiter.
// Muxes the granted source onto one downstream port with zero latency and no storage.
// Each packet's length comes from its header beat. Unlock is raised on the final beat,
// so the arbiter lock covers exactly one packet.
module bsg_locking_arb_unlocker #(
   parameter int inputs_p    = 16,
   parameter int width_p     = 32,
   parameter int len_width_p = 4,
   parameter int id_width_p  = (inputs_p == 1) ? 1 : $clog2(inputs_p)
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic [inputs_p-1:0]         grants_i,
   input  logic [inputs_p*width_p-1:0] data_i,
   output logic [inputs_p-1:0]         yumi_o,
   output logic                        arb_ready_o,
   output logic                        unlock_o,
   output logic                        v_o,
   output logic [width_p-1:0]          data_o,
   output logic [id_width_p-1:0]       id_o,
   output logic                        last_o,
   input  logic                        ready_i,
   output logic                        error_o
);

   typedef enum logic [0:0] {
      HDR  = 1'b0,
      BODY = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [len_width_p-1:0] r_cnt;
   logic [len_width_p-1:0] w_cnt_next;
   logic [id_width_p-1:0]  r_id;
   logic [id_width_p-1:0]  w_id_next;
   logic                   r_error;
   logic                   w_error_next;

   logic [width_p-1:0]     w_slice [inputs_p];
   logic [inputs_p-1:0]    w_id_hot;
   logic [width_p-1:0]     w_data;
   logic [id_width_p-1:0]  w_enc;
   logic [len_width_p-1:0] w_len;
   logic                   w_valid;
   logic                   w_fire;
   logic                   w_last;
   logic                   w_multi;
   logic                   w_wrong_src;

   // Per-source gated slice, plus a one-hot image of the locked id for the error check.
   for (genvar gi = 0; gi < inputs_p; gi++) begin : g_src
      assign w_slice[gi]  = data_i[gi*width_p +: width_p] & {width_p{grants_i[gi]}};
      assign w_id_hot[gi] = (r_id == id_width_p'(gi));
   end

   // AND-OR mux of the granted beat and a binary encoding of the grant vector.
   always_comb begin
      w_data = '0;
      w_enc  = '0;
      for (int i = 0; i < inputs_p; i++) begin
         w_data = w_data | w_slice[i];
         if (grants_i[i]) begin
            w_enc = w_enc | id_width_p'(i);
         end
      end
   end

   // Handshake signals. While reset is held, the arbiter is kept unlocked and the datapath is kept quiet.
   assign w_len       = w_data[len_width_p-1:0];
   assign w_valid     = reset_n_i & (|grants_i);
   assign w_fire      = w_valid & ready_i;
   assign v_o         = w_valid;
   assign data_o      = w_data;
   assign arb_ready_o = reset_n_i & ready_i;
   assign yumi_o      = grants_i & {inputs_p{w_fire}};
   assign last_o      = w_last;
   assign unlock_o    = ~reset_n_i | (w_fire & w_last);
   assign error_o     = r_error;

   // Protocol violations: the grant is not one-hot, or the grant inside a packet is not the locked source.
   assign w_multi      = |(grants_i & (grants_i - inputs_p'(1)));
   assign w_wrong_src  = (r_state == BODY) & (|grants_i) & (grants_i != w_id_hot);
   assign w_error_next = r_error | w_multi | w_wrong_src;

   // Packet framing: the next state, the beat counter, the locked id and the last-beat flag.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_id_next    = r_id;
      w_last       = 1'b0;
      id_o         = w_enc;
      case (r_state)
         HDR: begin
            id_o   = w_enc;
            w_last = w_valid & (w_len == '0);
            if (w_fire && (w_len != '0)) begin
               w_cnt_next   = w_len;
               w_id_next    = w_enc;
               w_state_next = BODY;
            end
         end
         BODY: begin
            id_o   = r_id;
            w_last = w_valid & (r_cnt == len_width_p'(1));
            if (w_fire) begin
               w_cnt_next = r_cnt - len_width_p'(1);
               if (r_cnt == len_width_p'(1)) begin
                  w_state_next = HDR;
               end
            end
         end
         default: w_state_next = HDR;
      endcase
   end

   // Registered framing state and sticky error. Reset returns to header-expecting state at once.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= HDR;
         r_cnt   <= '0;
         r_id    <= '0;
         r_error <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_id    <= w_id_next;
         r_error <= w_error_next;
      end
   end

endmodule

// File: tb/tb_bsg_locking_arb_unlocker.sv
// Self-checking bench for bsg_locking_arb_unlocker: directed packet scenarios plus randomized arbiter-like traffic.
module tb_bsg_locking_arb_unlocker;
   localparam int N   = 16;
   localparam int W   = 32;
   localparam int IDW = 4;

   logic           clk_i = 1'b0;
   logic           reset_n_i;
   logic [N-1:0]   grants_i;
   logic [N*W-1:0] data_i;
   logic [N-1:0]   yumi_o;
   logic           arb_ready_o;
   logic           unlock_o;
   logic           v_o;
   logic [W-1:0]   data_o;
   logic [IDW-1:0] id_o;
   logic           last_o;
   logic           ready_i;
   logic           error_o;

   int compared   = 0;
   int mismatched = 0;

   // Model state: beats still owed in the current packet (0 = expecting header), locked source, error flag.
   int m_rem = 0;
   int m_id  = 0;
   bit m_err = 1'b0;

   bsg_locking_arb_unlocker #(.inputs_p(N), .width_p(W), .len_width_p(4)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .grants_i(grants_i), .data_i(data_i),
      .yumi_o(yumi_o), .arb_ready_o(arb_ready_o), .unlock_o(unlock_o), .v_o(v_o),
      .data_o(data_o), .id_o(id_o), .last_o(last_o), .ready_i(ready_i), .error_o(error_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the packet-level model, taken on the falling edge.
   always @(negedge clk_i) begin : compare
      int pop;
      int idx;
      int len;
      bit any;
      bit fire;
      bit hdr;
      bit last;
      logic [W-1:0] exp_data;
      pop = $countones(grants_i);
      any = (pop != 0);
      idx = 0;
      for (int k = N - 1; k >= 0; k--) if (grants_i[k]) idx = k;
      if (!reset_n_i) begin
         check("rst_unlock", unlock_o, 1);
         check("rst_arb_ready", arb_ready_o, 0);
         check("rst_v", v_o, 0);
         check("rst_yumi", yumi_o, 0);
         check("rst_error", error_o, 0);
         m_rem = 0;
         m_id  = 0;
         m_err = 1'b0;
      end else begin
         exp_data = (pop == 1) ? data_i[idx*W +: W] : '0;
         fire = any && ready_i;
         hdr  = (m_rem == 0);
         len  = int'(exp_data[3:0]);
         last = hdr ? (len == 0) : (m_rem == 1);
         check("v_o", v_o, any);
         check("arb_ready_o", arb_ready_o, ready_i);
         check("yumi_o", yumi_o, fire ? grants_i : '0);
         check("error_o", error_o, m_err);
         if (pop <= 1) check("data_o", data_o, exp_data);
         if (pop == 1) begin
            check("id_o", id_o, hdr ? idx : m_id);
            check("last_o", last_o, last);
            check("unlock_o", unlock_o, fire && last);
         end else if (!fire) begin
            check("unlock_idle", unlock_o, 0);
         end
         if (pop > 1 || (!hdr && any && idx != m_id)) m_err = 1'b1;
         if (fire && pop == 1) begin
            if (hdr) begin
               if (len != 0) begin
                  m_rem = len;
                  m_id  = idx;
               end
            end else begin
               m_rem--;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic rnd_data();
      for (int k = 0; k < N; k++) data_i[k*W +: W] = $urandom;
   endtask

   task automatic set_hdr(input int src, input int len);
      logic [W-1:0] v;
      v = $urandom;
      v[3:0] = 4'(len);
      data_i[src*W +: W] = v;
   endtask

   initial begin : stim
      bit locked;
      int lsrc;
      locked    = 1'b0;
      lsrc      = 0;
      reset_n_i = 1'b0;
      grants_i  = '0;
      ready_i   = 1'b0;
      data_i    = '0;
      tick(); tick();
      #2;
      check("lit_rst_unlock", unlock_o, 1);
      check("lit_rst_v", v_o, 0);
      check("lit_rst_err", error_o, 0);
      tick();
      reset_n_i = 1'b1;
      tick();

      // Single-beat packet from source 3.
      rnd_data(); set_hdr(3, 0); grants_i = 16'h0008; ready_i = 1'b1;
      #2;
      check("lit_single_yumi", yumi_o, 16'h0008);
      check("lit_single_id", id_o, 3);
      check("lit_single_last", last_o, 1);
      check("lit_single_unlock", unlock_o, 1);
      $display("single-beat packet src 3 done");
      tick();

      // Four-beat packet from source 5, then source 1 header back-to-back.
      rnd_data(); set_hdr(5, 3); grants_i = 16'h0020;
      #2;
      check("lit_multi_hdr_id", id_o, 5);
      check("lit_multi_hdr_unlock", unlock_o, 0);
      tick();
      for (int b = 1; b <= 3; b++) begin
         rnd_data(); grants_i = 16'h0020;
         #2;
         check("lit_multi_id", id_o, 5);
         check("lit_multi_unlock", unlock_o, (b == 3));
         check("lit_multi_last", last_o, (b == 3));
         tick();
      end
      rnd_data(); set_hdr(1, 0); grants_i = 16'h0002;
      #2;
      check("lit_nobubble_v", v_o, 1);
      check("lit_nobubble_unlock", unlock_o, 1);
      check("lit_nobubble_id", id_o, 1);
      $display("four-beat packet src 5 then src 1 done");
      tick();

      // Backpressure inside a packet from source 2.
      rnd_data(); set_hdr(2, 2); grants_i = 16'h0004;
      #2;
      check("lit_bp_hdr_unlock", unlock_o, 0);
      tick();
      for (int b = 0; b < 2; b++) begin
         grants_i = '0; ready_i = 1'b0;
         #2;
         check("lit_bp_stall_v", v_o, 0);
         check("lit_bp_stall_unlock", unlock_o, 0);
         tick();
      end
      for (int b = 1; b <= 2; b++) begin
         rnd_data(); grants_i = 16'h0004; ready_i = 1'b1;
         #2;
         check("lit_bp_unlock", unlock_o, (b == 2));
         tick();
      end
      grants_i = '0;
      $display("backpressured packet src 2 done");
      tick();

      // Wrong source inside a packet sets the sticky error.
      rnd_data(); set_hdr(5, 3); grants_i = 16'h0020;
      tick();
      rnd_data(); grants_i = 16'h0004;
      #2;
      check("lit_err_before", error_o, 0);
      tick();
      grants_i = '0;
      #2;
      check("lit_err_set", error_o, 1);
      tick();
      #2;
      check("lit_err_sticky", error_o, 1);
      reset_n_i = 1'b0;
      #1;
      check("lit_err_cleared", error_o, 0);
      tick();
      reset_n_i = 1'b1;
      tick();
      grants_i = 16'h0011; ready_i = 1'b0;
      tick();
      grants_i = '0; ready_i = 1'b1;
      #2;
      check("lit_err_multihot", error_o, 1);
      tick();
      reset_n_i = 1'b0;
      tick();
      reset_n_i = 1'b1;
      $display("error scenarios done");
      tick();

      // Maximum-length packet from source 7.
      rnd_data(); set_hdr(7, 15); grants_i = 16'h0080;
      #2;
      check("lit_max_hdr_unlock", unlock_o, 0);
      tick();
      for (int b = 1; b <= 15; b++) begin
         rnd_data(); grants_i = 16'h0080;
         #2;
         check("lit_max_unlock", unlock_o, (b == 15));
         check("lit_max_last", last_o, (b == 15));
         tick();
      end
      rnd_data(); set_hdr(9, 0); grants_i = 16'h0200;
      #2;
      check("lit_max_after", unlock_o, 1);
      $display("sixteen-beat packet src 7 done");
      tick();

      // Randomized arbiter-like traffic with occasional reset.
      for (int c = 0; c < 4000; c++) begin
         reset_n_i = ($urandom_range(0, 299) != 0);
         ready_i   = ($urandom_range(0, 3) != 0);
         rnd_data();
         for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 3) != 0) data_i[k*W +: 4] = 4'($urandom_range(0, 3));
         end
         if (!reset_n_i) locked = 1'b0;
         if (locked) begin
            grants_i = ready_i ? (16'(1) << lsrc) : '0;
         end else if ($urandom_range(0, 3) == 0) begin
            grants_i = '0;
         end else begin
            lsrc     = $urandom_range(0, N - 1);
            grants_i = 16'(1) << lsrc;
         end
         #2;
         if (unlock_o) locked = 1'b0;
         else if (v_o && ready_i) locked = 1'b1;
         tick();
      end
      $display("random traffic done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
